systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 137 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - loads A/B operand rows, streams them diagonally skewed, sequences readout
// Optional readout phase: SKEW_FEEDER_AUTOREADOUT_EN
module systolic_skew_feeder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic         out_readout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] BEAT_LAST   = CW'(2 * N - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(2 * N - 2);
    localparam logic [CW-1:0] READ_LAST   = CW'(N - 1);

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        READOUT
    } state_t;

    state_t        state;
    logic [CW-1:0] beat;
    logic [CW-1:0] phase;
    logic [N-1:0]  a_row [N];
    logic [N-1:0]  b_row [N];
    logic [CW-1:0] next_t;
    logic [N-1:0]  a_next;
    logic [N-1:0]  b_next;
    logic          accept;

    // in_ready is gated by rst_n so it reads 0 while reset is held
    assign in_ready = rst_n && (state == LOAD);
    assign busy     = (state != LOAD);
    assign accept   = in_valid && in_ready && !flush;

    // Beat to be presented after the coming edge: 0 on the final load beat
    assign next_t = (state == STREAM) ? phase + 1'b1 : '0;

    always_comb begin
        a_next = '0;
        b_next = '0;
        for (int i = 0; i < N; i++) begin
            for (int r = 0; r < N; r++) begin
                if (int'(next_t) == r + i) begin
                    a_next[i] = a_row[r][i];
                    b_next[i] = b_row[r][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            beat        <= '0;
            phase       <= '0;
            a_out       <= '0;
            b_out       <= '0;
            out_readout <= 1'b0;
            done        <= 1'b0;
            for (int k = 0; k < N; k++) begin
                a_row[k] <= '0;
                b_row[k] <= '0;
            end
        end else if (flush) begin
            state       <= LOAD;
            beat        <= '0;
            phase       <= '0;
            a_out       <= '0;
            b_out       <= '0;
            out_readout <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        for (int k = 0; k < N; k++) begin
                            if (beat == CW'(k))     a_row[k] <= in_data;
                            if (beat == CW'(k + N)) b_row[k] <= in_data;
                        end
                        if (beat == BEAT_LAST) begin
                            state <= STREAM;
                            beat  <= '0;
                            phase <= '0;
                            a_out <= a_next;
                            b_out <= b_next;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (phase == STREAM_LAST) begin
                        a_out <= '0;
                        b_out <= '0;
                        phase <= '0;
`ifdef SKEW_FEEDER_AUTOREADOUT_EN
                        state       <= READOUT;
                        out_readout <= 1'b1;
`else
                        state <= LOAD;
                        done  <= 1'b1;
`endif
                    end else begin
                        phase <= phase + 1'b1;
                        a_out <= a_next;
                        b_out <= b_next;
                    end
                end
`ifdef SKEW_FEEDER_AUTOREADOUT_EN
                READOUT: begin
                    if (phase == READ_LAST) begin
                        state       <= LOAD;
                        phase       <= '0;
                        out_readout <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
`endif
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed self-checking bench for systolic_skew_feeder (N = 8)
module tb_systolic_skew_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       out_readout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] rows_ones [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] rows_id   [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] rows_zero [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_ones [15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    logic [7:0] exp_id   [15] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00,
                                  8'h10, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h80};
    logic [7:0] exp_zero [15] = '{default: 8'h00};

    systolic_skew_feeder #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .a_out       (a_out),
        .b_out       (b_out),
        .out_readout (out_readout),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [7:0] ra [8], input logic [7:0] rb [8], input bit bp);
        for (int k = 0; k < 16; k++) begin
            in_data  = (k < 8) ? ra[k] : rb[k-8];
            in_valid = 1'b1;
            if (k == 15) check_eq("busy_before_e0", busy, 0);
            step();
            if (bp && k < 15) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                step();
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic check_stream(input string tag, input logic [7:0] ea [15], input logic [7:0] eb [15]);
        for (int t = 0; t < 15; t++) begin
            check_eq($sformatf("%s_a_beat%0d", tag, t), a_out, ea[t]);
            check_eq($sformatf("%s_b_beat%0d", tag, t), b_out, eb[t]);
            step();
        end
    endtask

    task automatic finish_job(input string tag);
`ifdef SKEW_FEEDER_AUTOREADOUT_EN
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("%s_readout%0d", tag, c), out_readout, 1);
            check_eq($sformatf("%s_nodone%0d", tag, c), done, 0);
            check_eq($sformatf("%s_ro_a%0d", tag, c), a_out, 0);
            step();
        end
`endif
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_ready"}, in_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ro_off"}, out_readout, 0);
        check_eq({tag, "_a_zero"}, a_out, 0);
        step();
        check_eq({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        bit seen_done;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        flush    = 1'b0;

        step();
        check_eq("rst_in_ready", in_ready, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_eq("rst_a_out", a_out, 0);
        check_eq("rst_b_out", b_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_readout", out_readout, 0);
        check_eq("rst_in_ready_after", in_ready, 1);

        load_job(rows_ones, rows_ones, 1'b0);
        check_stream("ones", exp_ones, exp_ones);
        finish_job("ones");

        load_job(rows_id, rows_zero, 1'b0);
        check_stream("ident", exp_id, exp_zero);
        finish_job("ident");

        load_job(rows_ones, rows_id, 1'b1);
        check_eq("bp_busy_e0", busy, 1);
        check_stream("bp", exp_ones, exp_id);
        finish_job("bp");

        load_job(rows_ones, rows_ones, 1'b0);
        for (int t = 0; t < 5; t++) step();
        check_eq("flush_pre_beat5", a_out, 8'h3F);
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_ready", in_ready, 1);
        check_eq("flush_a", a_out, 0);
        check_eq("flush_b", b_out, 0);
        check_eq("flush_ro", out_readout, 0);
        check_eq("flush_done", done, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        check_eq("flush_no_done", seen_done, 0);
        load_job(rows_id, rows_ones, 1'b0);
        check_stream("post_flush", exp_id, exp_ones);
        finish_job("post_flush");

        load_job(rows_ones, rows_ones, 1'b0);
`ifdef SKEW_FEEDER_AUTOREADOUT_EN
        check_stream("pre_arst", exp_ones, exp_ones);
        step();
        step();
        step();
        check_eq("arst_readout_before", out_readout, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_readout_async", out_readout, 0);
`else
        for (int t = 0; t < 5; t++) step();
        check_eq("arst_a_before", a_out, 8'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_a_async", a_out, 0);
        check_eq("arst_b_async", b_out, 0);
`endif
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ready_low", in_ready, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_eq("arst_ready_after", in_ready, 1);
        check_eq("arst_busy_after", busy, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        check_eq("arst_no_done", seen_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
